// File: rtl/tt_alu_accum.sv
// Registered ADD/AND/XOR/ACC datapath with a 1-deep valid/ready output stage, running accumulator and op counter.
// Optional build macro TT_ALU_SATURATE_EN: ADD and ACC clamp to all-ones on carry instead of wrapping.
module tt_alu_accum #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             carry,
  output logic [W-1:0]     acc,
  output logic [CNT_W-1:0] op_count,
  output logic             dbg_state
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  state_t             r_state;
  logic [W-1:0]       r_result;
  logic               r_carry;
  logic [W-1:0]       r_acc;
  logic [CNT_W-1:0]   r_count;

  logic               w_accept;
  logic               w_pop;
  logic [W-1:0]       w_acc_base;
  logic [W:0]         w_sum;
  logic               w_carry;
  logic [W-1:0]       w_res;

  // Handshake: accept = in_valid & in_ready; pop = out_valid & out_ready.
  // in_ready is high whenever the output stage is empty or being drained this cycle.
  assign in_ready  = (r_state == ST_EMPTY) | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = (r_state == ST_FULL) & out_ready;

  assign w_acc_base = acc_clr ? '0 : r_acc;

  always_comb begin
    w_sum   = '0;
    w_carry = 1'b0;
    case (op)
      OP_ADD:  w_sum = {1'b0, a} + {1'b0, b};
      OP_AND:  w_sum = {1'b0, a & b};
      OP_XOR:  w_sum = {1'b0, a ^ b};
      default: w_sum = {1'b0, w_acc_base} + {1'b0, a};
    endcase
    w_carry = w_sum[W];
`ifdef TT_ALU_SATURATE_EN
    w_res = w_carry ? {W{1'b1}} : w_sum[W-1:0];
`else
    w_res = w_sum[W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_acc    <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_FULL;
        ST_FULL:  if (w_pop && !w_accept) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
      if (w_accept) begin
        r_result <= w_res;
        r_carry  <= w_carry;
        r_count  <= r_count + CNT_W'(1);
      end
      // An accepted ACC already folds acc_clr into its base value.
      if (w_accept && (op == OP_ACC)) r_acc <= w_res;
      else if (acc_clr)               r_acc <= '0;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign result    = r_result;
  assign carry     = r_carry;
  assign acc       = r_acc;
  assign op_count  = r_count;
  assign dbg_state = r_state;

  logic w_unused;
  assign w_unused = w_pop & (OP_ADD == 2'b00) & (OP_AND == 2'b01) & (OP_XOR == 2'b10);

endmodule

// File: tb/tb_tt_alu_accum.sv
// Bench for tt_alu_accum: directed scenarios plus random traffic, all checked cycle by cycle against a queue model.
module tb_tt_alu_accum;
  localparam int W     = 8;
  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << W) - 1;
`ifdef TT_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = 2'b00;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             acc_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     result;
  logic             carry;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] op_count;
  logic             dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: pending outputs as {carry,result}, accumulator and counter as plain integers.
  logic [W:0] exp_q[$];
  int         m_acc = 0;
  int         m_cnt = 0;

  tt_alu_accum #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .acc(acc), .op_count(op_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Called at posedge+1; drives one cycle of inputs, advances the model and checks the DUT.
  task automatic step(input logic v, input logic [1:0] o, input logic [W-1:0] ai,
                      input logic [W-1:0] bi, input logic clr, input logic ordy);
    int  s;
    int  base;
    int  r;
    bit  c;
    bit  exp_ready;
    bit  accept;
    bit  pop;
    in_valid = v; op = o; a = ai; b = bi; acc_clr = clr; out_ready = ordy;
    #1;
    exp_ready = (exp_q.size() == 0) || ordy;
    n_checks++;
    if (in_ready !== exp_ready) begin
      n_errors++;
      $display("FAIL in_ready: got %b exp %b at %0t", in_ready, exp_ready, $time);
    end
    accept = v && exp_ready;
    pop    = (exp_q.size() != 0) && ordy;
    base   = clr ? 0 : m_acc;
    s = 0; c = 1'b0; r = 0;
    if (accept) begin
      case (o)
        2'b00:   s = int'(ai) + int'(bi);
        2'b01:   s = int'(ai & bi);
        2'b10:   s = int'(ai ^ bi);
        default: s = base + int'(ai);
      endcase
      c = (s > MAXV);
      r = s % (MAXV + 1);
      if (SAT && c) r = MAXV;
    end
    if (accept && o == 2'b11) m_acc = r;
    else if (clr)             m_acc = 0;
    if (pop) void'(exp_q.pop_front());
    if (accept) begin
      exp_q.push_back({c, W'(r)});
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      n_errors++;
      $display("FAIL out_valid: got %b exp %b at %0t", out_valid, exp_q.size() != 0, $time);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      if ({carry, result} !== exp_q[0]) begin
        n_errors++;
        $display("FAIL carry_result: got %h exp %h at %0t", {carry, result}, exp_q[0], $time);
      end
    end
    n_checks++;
    if (acc !== W'(m_acc)) begin
      n_errors++;
      $display("FAIL acc: got %h exp %h at %0t", acc, W'(m_acc), $time);
    end
    n_checks++;
    if (op_count !== CNT_W'(m_cnt)) begin
      n_errors++;
      $display("FAIL op_count: got %0d exp %0d at %0t", op_count, m_cnt, $time);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, result, carry, acc, op_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got %b exp 0", {out_valid, result, carry, acc, op_count});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    // Load the output stage and accumulator, then reset mid-transfer.
    step(1, 2'b11, 8'h33, 8'h00, 0, 0);
    step(1, 2'b00, 8'h11, 8'h22, 0, 0);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, result, carry, acc, op_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: got %b exp 0", {out_valid, result, carry, acc, op_count});
    end
    exp_q.delete();
    m_acc = 0;
    m_cnt = 0;
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    step(1, 2'b00, 8'hF0, 8'h20, 0, 1);
    n_checks++;
    if ({carry, result} !== (SAT ? 9'h1FF : 9'h110)) begin
      n_errors++;
      $display("FAIL add_carry: got %h exp %h", {carry, result}, SAT ? 9'h1FF : 9'h110);
    end
    step(1, 2'b00, 8'h12, 8'h34, 0, 1);
    step(0, 2'b00, 8'h00, 8'h00, 0, 1);
  endtask

  task automatic test_and_xor();
    step(1, 2'b01, 8'hCC, 8'hAA, 0, 1);
    n_checks++;
    if ({carry, result} !== 9'h088) begin
      n_errors++;
      $display("FAIL and_value: got %h exp 088", {carry, result});
    end
    step(1, 2'b10, 8'hCC, 8'hAA, 0, 1);
    n_checks++;
    if ({out_valid, carry, result} !== 10'h266) begin
      n_errors++;
      $display("FAIL xor_b2b: got %h exp 266", {out_valid, carry, result});
    end
    step(0, 2'b00, 8'h00, 8'h00, 0, 1);
  endtask

  task automatic test_backpressure();
    int c0;
    c0 = m_cnt;
    step(1, 2'b00, 8'h01, 8'h02, 0, 0);
    step(1, 2'b00, 8'h40, 8'h05, 0, 0);
    step(1, 2'b00, 8'h40, 8'h05, 0, 0);
    step(1, 2'b00, 8'h40, 8'h05, 0, 1);
    step(0, 2'b00, 8'h00, 8'h00, 0, 1);
    n_checks++;
    if (int'(op_count) != (c0 + 2) % 256 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL backpressure_count: got %0d/%b exp %0d/0", op_count, out_valid, (c0 + 2) % 256);
    end
  endtask

  task automatic test_acc();
    step(0, 2'b00, 8'h00, 8'h00, 1, 1);
    step(1, 2'b11, 8'h80, 8'h00, 0, 1);
    step(1, 2'b11, 8'h80, 8'h00, 0, 1);
    n_checks++;
    if ({carry, acc} !== (SAT ? 9'h1FF : 9'h100)) begin
      n_errors++;
      $display("FAIL acc_overflow: got %h exp %h", {carry, acc}, SAT ? 9'h1FF : 9'h100);
    end
    step(1, 2'b11, 8'h80, 8'h00, 0, 1);
    step(1, 2'b11, 8'h05, 8'h77, 1, 1);
    n_checks++;
    if ({carry, acc, result} !== 17'h00505) begin
      n_errors++;
      $display("FAIL acc_clr_acc: got %h exp 00505", {carry, acc, result});
    end
    // Stalled ACC must not touch the accumulator.
    step(1, 2'b11, 8'h10, 8'h00, 0, 0);
    step(1, 2'b11, 8'h10, 8'h00, 0, 0);
    step(0, 2'b00, 8'h00, 8'h00, 0, 1);
  endtask

  task automatic test_wrap_clr();
    int c0;
    c0 = m_cnt;
    for (int i = 0; i < 256; i++) step(1, 2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 0, 1);
    n_checks++;
    if (int'(op_count) != c0) begin
      n_errors++;
      $display("FAIL count_wrap: got %0d exp %0d", op_count, c0);
    end
    step(1, 2'b11, 8'h21, 8'h00, 0, 0);
    step(0, 2'b00, 8'h00, 8'h00, 1, 0);
    step(0, 2'b00, 8'h00, 8'h00, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0));
  endtask

  initial begin
    test_reset();
    test_add();
    test_and_xor();
    test_backpressure();
    test_acc();
    test_wrap_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
